// File: rtl/usb_host_tx_scheduler.sv
// Packet-granular arbiter for the shared USB host PHY transmit path.
// Whole-packet grants, inter-packet gap, frame timer with end-of-frame guard, stall watchdog.

module usb_host_tx_req_lane #(
  parameter bit URGENT = 1'b0
) (
  input  logic valid_i,
  input  logic sel_i,
  input  logic phy_ready_i,
  input  logic eof_win_i,
  output logic elig_o,
  output logic ready_o
);
  // Only the urgent requester may open a packet inside the end-of-frame guard
  assign elig_o  = valid_i & (URGENT | ~eof_win_i);
  assign ready_o = sel_i & phy_ready_i;
endmodule

module usb_host_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 60000,
  parameter int EOF_GUARD    = 1200,
  parameter int IPG_CYCLES   = 4,
  parameter int STALL_CYCLES = 256,
  localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int FW  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1,
  localparam int SW  = $clog2(STALL_CYCLES + 1),
  localparam int GPW = $clog2(IPG_CYCLES + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           phy_tx_data,
  output logic                 phy_tx_valid,
  input  logic                 phy_tx_ready,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_id,
  output logic                 frame_start,
  output logic                 err_stall
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  state_e           st_q, st_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic [GPW-1:0]   gap_q, gap_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [FW-1:0]    frm_q, frm_d;
  logic             fs_q, err_q, err_d;
  logic             frame_wrap, eof_win, xfer;
  logic [NUM_REQ-1:0] elig;
  logic             any_elig, acc, acc_last, stall_hit;
  logic [GW-1:0]    pick;

  // Frame timer
  always_comb begin
    frame_wrap = (frm_q == FW'(FRAME_CYCLES - 1));
    frm_d      = frame_wrap ? '0 : frm_q + FW'(1);
    eof_win    = (EOF_GUARD > 0) && (frm_q >= FW'(FRAME_CYCLES - EOF_GUARD));
  end

  assign xfer = (st_q == XFER);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    usb_host_tx_req_lane #(.URGENT(i == 0)) u_lane (
      .valid_i     (req_valid[i]),
      .sel_i       (xfer && (gid_q == GW'(i))),
      .phy_ready_i (phy_tx_ready),
      .eof_win_i   (eof_win),
      .elig_o      (elig[i]),
      .ready_o     (req_ready[i])
    );
  end

  // Lowest index wins
  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        any_elig = 1'b1;
        pick     = GW'(i);
      end
    end
  end

  assign grant_valid  = xfer;
  assign grant_id     = gid_q;
  assign phy_tx_valid = xfer & req_valid[gid_q];
  assign phy_tx_data  = xfer ? req_data[{gid_q, 3'b000} +: 8] : 8'h00;
  assign frame_start  = fs_q;
  assign err_stall    = err_q;

  always_comb begin
    acc       = phy_tx_valid & phy_tx_ready;
    acc_last  = acc & req_last[gid_q];
    stall_hit = ~acc && (stall_q == SW'(STALL_CYCLES - 1));
  end

  always_comb begin
    st_d    = st_q;
    gid_d   = gid_q;
    gap_d   = gap_q;
    stall_d = stall_q;
    err_d   = 1'b0;
    unique case (st_q)
      IDLE: begin
        stall_d = '0;
        if (any_elig) begin
          gid_d = pick;
          st_d  = XFER;
        end
      end
      XFER: begin
        // A last-byte accept always wins over a coincident timeout
        if (acc) begin
          stall_d = '0;
          if (acc_last) begin
            st_d  = GAP;
            gap_d = GPW'(IPG_CYCLES);
          end
        end else if (stall_hit) begin
          st_d    = GAP;
          gap_d   = GPW'(IPG_CYCLES);
          stall_d = '0;
          err_d   = 1'b1;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      GAP: begin
        // Leave on the cycle the count reaches 1 (or starts at 0): GAP spans max(IPG,1) cycles
        if (gap_q != '0) gap_d = gap_q - GPW'(1);
        if (gap_q <= GPW'(1)) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      gid_q   <= '0;
      gap_q   <= '0;
      stall_q <= '0;
      frm_q   <= '0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      gid_q   <= gid_d;
      gap_q   <= gap_d;
      stall_q <= stall_d;
      frm_q   <= frm_d;
      fs_q    <= frame_wrap;
      err_q   <= err_d;
    end
  end

endmodule
